// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking write-back, write-allocate data cache controller for an external tag/data SRAM
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   cpu_req_i/write_i      CPU access valid / 1=store, 0=load
//   cpu_addr_i             byte address {tag[31:9], index[8:5], word[4:2], byte[1:0]}
//   cpu_data_i/o           store data in / load data out
//   cpu_stall_o            CPU must hold its request this cycle
//   mem_*                  line-wide memory port: write-back or fill, completed by a one-cycle mem_ack_i
//   sram_*                 set-indexed SRAM port; sram_hit_i, sram_tag_i and sram_data_i respond combinationally
module dcache_ctrl #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int WORD_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_write_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [WORD_W-1:0] cpu_data_i,
   output logic [WORD_W-1:0] cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [3:0]        sram_addr_o,
   output logic [ADDR_W-8:0] sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [ADDR_W-8:0] sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i
);
   localparam int TAG_W = ADDR_W - 9;
   typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, FILL, FILL_DONE} state_e;
   state_e            state_q, state_d;
   logic [TAG_W+1:0]  victim_tag_q, victim_tag_d;
   logic [LINE_W-1:0] victim_line_q, victim_line_d;
   logic [LINE_W-1:0] fill_line_q, fill_line_d;
   logic [LINE_W-1:0] merged;
   logic [TAG_W-1:0]  cpu_tag;
   logic [3:0]        index;
   logic [2:0]        word;
   logic              miss;
   logic              unused_byte_sel;
   assign cpu_tag         = cpu_addr_i[ADDR_W-1:9];
   assign index           = cpu_addr_i[8:5];
   assign word            = cpu_addr_i[4:2];
   assign unused_byte_sel = ^cpu_addr_i[1:0];
   assign miss            = cpu_req_i & ~sram_hit_i;
   assign sram_addr_o     = index;
   assign sram_enable_o   = cpu_req_i;
   assign cpu_data_o      = sram_data_i[int'(word)*WORD_W +: WORD_W];
   // Store-hit line: the SRAM line with the addressed word replaced
   always_comb begin
      merged = sram_data_i;
      merged[int'(word)*WORD_W +: WORD_W] = cpu_data_i;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         victim_tag_q  <= '0;
         victim_line_q <= '0;
         fill_line_q   <= '0;
      end else begin
         state_q       <= state_d;
         victim_tag_q  <= victim_tag_d;
         victim_line_q <= victim_line_d;
         fill_line_q   <= fill_line_d;
      end
   end
   always_comb begin
      state_d       = state_q;
      victim_tag_d  = victim_tag_q;
      victim_line_d = victim_line_q;
      fill_line_d   = fill_line_q;
      cpu_stall_o   = 1'b1;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      sram_write_o  = 1'b0;
      sram_tag_o    = {2'b11, cpu_tag};
      sram_data_o   = merged;
      case (state_q)
         IDLE: begin
            cpu_stall_o  = miss;
            sram_write_o = cpu_req_i & cpu_write_i & sram_hit_i;
            if (miss) begin
               state_d       = MISS;
               victim_tag_d  = sram_tag_i;
               victim_line_d = sram_data_i;
            end
         end
         // Only a valid and dirty victim needs to reach memory before the fill
         MISS: state_d = (victim_tag_q[TAG_W+1] & victim_tag_q[TAG_W]) ? WRITEBACK : FILL;
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {victim_tag_q[TAG_W-1:0], index, 5'b0};
            mem_data_o   = victim_line_q;
            if (mem_ack_i) state_d = FILL;
         end
         FILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {cpu_tag, index, 5'b0};
            if (mem_ack_i) begin
               fill_line_d = mem_data_i;
               state_d     = FILL_DONE;
            end
         end
         // Install clean; a pending store then hits in IDLE and marks the line dirty
         FILL_DONE: begin
            sram_write_o = 1'b1;
            sram_data_o  = fill_line_q;
            sram_tag_o   = {2'b10, cpu_tag};
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random accesses against a flat-memory / direct-mapped cache reference model
module tb_dcache_ctrl;
   logic         clk_i = 1'b0, rst_i = 1'b1;
   logic         cpu_req_i = 1'b0, cpu_write_i = 1'b0, mem_ack_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o, mem_addr_o;
   logic         cpu_stall_o, mem_enable_o, mem_write_o, sram_enable_o, sram_write_o, sram_hit_i;
   logic [255:0] mem_data_o, mem_data_i = '0, sram_data_o, sram_data_i;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o, sram_tag_i;
   int           checks = 0, errors = 0;

   dcache_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .mem_ack_i(mem_ack_i), .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
      .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
      .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
   );

   always #5 clk_i = ~clk_i;

   // External SRAM: 16 sets, combinational read, written on the clock edge
   logic [24:0]  sv_tag [16];
   logic [255:0] sv_line [16];
   logic         pre_en = 1'b0;
   logic [3:0]   pre_idx = '0;
   logic [24:0]  pre_tag = '0;
   logic [255:0] pre_line = '0;
   always @(posedge clk_i)
      if (pre_en) begin
         sv_tag[pre_idx]  <= pre_tag;
         sv_line[pre_idx] <= pre_line;
      end else if (sram_write_o) begin
         sv_tag[sram_addr_o]  <= sram_tag_o;
         sv_line[sram_addr_o] <= sram_data_o;
      end
   assign sram_tag_i  = sv_tag[sram_addr_o];
   assign sram_data_i = sv_line[sram_addr_o];
   assign sram_hit_i  = sram_tag_i[24] && sram_tag_i[22:0] == cpu_addr_i[31:9];

   // Reference: flat architectural memory, backing memory lines, and a direct-mapped directory
   logic [31:0]  gold [logic [31:0]];
   logic [255:0] mmem [logic [31:0]];
   logic         mv [16], md [16];
   logic [22:0]  mt [16];

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : (a ^ 32'hA5A5_0F0F);
   endfunction
   function automatic logic [255:0] gold_line(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = gold_rd(base + 32'(k*4));
      return l;
   endfunction
   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      if (mmem.exists(a)) return mmem[a];
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = (a + 32'(k*4)) ^ 32'hA5A5_0F0F;
      return l;
   endfunction

   task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int wl, input int fl);
      logic [3:0]   idx;
      logic [22:0]  tg;
      logic [31:0]  wa;
      logic         hit, dirty_miss, wb_seen;
      logic [255:0] nl;
      int           stalls, cnt, exp_stalls;
      idx = a[8:5];
      tg = a[31:9];
      wa = {a[31:2], 2'b0};
      hit = mv[idx] && mt[idx] == tg;
      dirty_miss = !hit && mv[idx] && md[idx];
      exp_stalls = hit ? 0 : 3 + fl + (dirty_miss ? wl : 0);
      @(negedge clk_i);
      cpu_req_i = 1'b1;
      cpu_write_i = w;
      cpu_addr_i = a;
      cpu_data_i = d;
      #1;
      chk("sram_en_idx", {sram_enable_o, sram_addr_o}, {1'b1, idx});
      stalls = 0;
      cnt = 0;
      wb_seen = 1'b0;
      while (cpu_stall_o === 1'b1 && stalls < 200) begin
         if (sram_write_o === 1'b1) begin
            chk("fill_tag", sram_tag_o, {2'b10, tg});
            chk("fill_line", sram_data_o, gold_line({tg, idx, 5'b0}));
         end
         if (mem_enable_o === 1'b1) begin
            cnt++;
            if (cnt == 1 && mem_write_o) begin
               chk("wb_addr", mem_addr_o, {mt[idx], idx, 5'b0});
               chk("wb_data", mem_data_o, gold_line({mt[idx], idx, 5'b0}));
            end
            if (cnt == 1 && !mem_write_o) chk("fill_addr", mem_addr_o, {tg, idx, 5'b0});
            if (cnt >= (mem_write_o ? wl : fl)) begin
               if (mem_write_o) begin
                  mmem[mem_addr_o] = mem_data_o;
                  wb_seen = 1'b1;
               end else mem_data_i = mem_line(mem_addr_o);
               mem_ack_i = 1'b1;
               cnt = 0;
            end
         end
         stalls++;
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         #1;
      end
      chk("stall_cycles", stalls, exp_stalls);
      chk("writeback_done", wb_seen, dirty_miss);
      chk("idle_mem_en", mem_enable_o, 1'b0);
      if (w) begin
         nl = gold_line({tg, idx, 5'b0});
         nl[int'(a[4:2])*32 +: 32] = d;
         chk("st_we", sram_write_o, 1'b1);
         chk("st_tag", sram_tag_o, {2'b11, tg});
         chk("st_line", sram_data_o, nl);
         gold[wa] = d;
      end else chk("ld_data", cpu_data_o, gold_rd(wa));
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = w | (hit & md[idx]);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
         mt[i] = '0;
      end
      gold[32'h24] = 32'hDEAD_BEEF;
      mmem[32'h20] = gold_line(32'h20);
      mv[1] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         pre_en = 1'b1;
         pre_idx = 4'(i);
         pre_tag = (i == 1) ? {2'b10, 23'd0} : '0;
         pre_line = (i == 1) ? gold_line(32'h20) : '0;
      end
      @(negedge clk_i);
      pre_en = 1'b0;
      #1;
      chk("reset_mem_en", mem_enable_o, 1'b0);
      chk("reset_sram_we", sram_write_o, 1'b0);
      chk("reset_stall", cpu_stall_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
      access(1'b0, 32'h0000_0024, 32'h0, 1, 1);
      access(1'b0, 32'h0000_1040, 32'h0, 1, 10);
      access(1'b1, 32'h0000_0444, 32'h1234_5678, 1, 2);
      access(1'b0, 32'h0000_1040, 32'h0, 4, 3);
      access(1'b1, 32'h0000_105C, 32'hCAFE_F00D, 1, 1);
      access(1'b0, 32'h0000_0444, 32'h0, 2, 2);
      @(negedge clk_i);
      cpu_req_i = 1'b1;
      cpu_write_i = 1'b0;
      cpu_addr_i = 32'h0000_20A0;
      #1;
      for (int i = 0; i < 20 && mem_enable_o !== 1'b1; i++) begin
         @(negedge clk_i);
         #1;
      end
      chk("fill_wait", {mem_enable_o, mem_write_o}, 2'b10);
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      chk("rst_mem_en", mem_enable_o, 1'b0);
      chk("rst_mem_wr", mem_write_o, 1'b0);
      chk("rst_sram_we", sram_write_o, 1'b0);
      cpu_req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      mem_ack_i = 1'b1;
      mem_data_i = {8{32'hBAD0_BAD0}};
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      chk("late_ack_mem_en", mem_enable_o, 1'b0);
      chk("late_ack_sram_we", sram_write_o, 1'b0);
      chk("late_ack_stall", cpu_stall_o, 1'b0);
      access(1'b0, 32'h0000_20A0, 32'h0, 2, 4);
      for (int n = 0; n < 80; n++)
         access(1'($urandom_range(0, 1)),
                {21'($urandom_range(0, 3)), 2'b0, 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b0},
                $urandom, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
